// File: rtl/ul_mcbsp_tx_arbiter.sv
// ul_mcbsp_tx_arbiter: shares one McBSP transmitter between data (ch0) and status (ch1) words.
// Optional UL_ARB_STATS_EN adds per-channel success counters and a timeout counter.
module ul_mcbsp_tx_arbiter #(
    parameter int DATA_W      = 16,
    parameter int MAX_CONSEC  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              McBSPClk,
    input  logic              nRst,
    input  logic              ch0_req,
    input  logic [DATA_W-1:0] ch0_data,
    output logic              ch0_ack,
    input  logic              ch1_req,
    input  logic [DATA_W-1:0] ch1_data,
    output logic              ch1_ack,
    output logic              tx_err,
    output logic              tRequest,
    output logic [DATA_W-1:0] tData,
    input  logic              busIdle,
    input  logic              send_done,
    output logic              err_sticky,
    output logic              active_ch,
    output logic              busy
`ifdef UL_ARB_STATS_EN
    ,
    output logic [15:0]       stat_ch0_cnt,
    output logic [15:0]       stat_ch1_cnt,
    output logic [7:0]        stat_err_cnt
`endif
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int CW = $clog2(MAX_CONSEC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              active_q, active_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              sticky_q, sticky_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [CW-1:0]     consec_q, consec_d;
    logic              pick1;
    logic              expire;

    assign pick1  = ch1_req && (!ch0_req || consec_q < CW'(MAX_CONSEC));
    assign expire = tcnt_q == TW'(TIMEOUT_CYC - 1);

    always_comb begin
        state_d  = state_q;
        tdata_d  = tdata_q;
        active_d = active_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        sticky_d = sticky_q;
        tcnt_d   = tcnt_q + TW'(1);
        consec_d = consec_q;
        case (state_q)
            IDLE: begin
                tcnt_d = '0;
                // No grant during the ack cycle so a requester can retire its word first
                if (busIdle && !ack_q && (ch0_req || ch1_req)) begin
                    state_d  = ISSUE;
                    tdata_d  = pick1 ? ch1_data : ch0_data;
                    active_d = pick1;
                    busy_d   = 1'b1;
                    consec_d = (pick1 && ch0_req)
                             ? ((consec_q == CW'(MAX_CONSEC)) ? consec_q : consec_q + CW'(1))
                             : '0;
                end
            end
            ISSUE: state_d = WAIT_START;
            default: begin
                if (send_done || expire) begin
                    state_d  = IDLE;
                    ack_d    = 1'b1;
                    busy_d   = 1'b0;
                    err_d    = !send_done;
                    sticky_d = sticky_q | !send_done;
                end else if (state_q == WAIT_START && !busIdle) begin
                    state_d = WAIT_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge McBSPClk) begin
        if (!nRst) begin
            state_q  <= IDLE;
            tdata_q  <= '0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            tcnt_q   <= '0;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= tdata_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            tcnt_q   <= tcnt_d;
            consec_q <= consec_d;
        end
    end

    assign ch0_ack    = ack_q && !active_q;
    assign ch1_ack    = ack_q && active_q;
    assign tx_err     = err_q;
    assign tRequest   = state_q == ISSUE;
    assign tData      = tdata_q;
    assign err_sticky = sticky_q;
    assign active_ch  = active_q;
    assign busy       = busy_q;

`ifdef UL_ARB_STATS_EN
    logic [15:0] st0_q, st1_q;
    logic [7:0]  ste_q;

    always_ff @(posedge McBSPClk) begin
        if (!nRst) begin
            st0_q <= '0;
            st1_q <= '0;
            ste_q <= '0;
        end else begin
            if (ack_d && !err_d && !active_q) st0_q <= st0_q + 16'd1;
            if (ack_d && !err_d && active_q)  st1_q <= st1_q + 16'd1;
            if (err_d)                        ste_q <= ste_q + 8'd1;
        end
    end

    assign stat_ch0_cnt = st0_q;
    assign stat_ch1_cnt = st1_q;
    assign stat_err_cnt = ste_q;
`endif
endmodule

// File: tb/tb_ul_mcbsp_tx_arbiter.sv
// tb_ul_mcbsp_tx_arbiter: randomized bench with a word-level reference model of the arbiter.
module tb_ul_mcbsp_tx_arbiter;
    localparam int TO = 1024;
    localparam int MC = 4;

    logic        McBSPClk = 1'b0;
    logic        nRst = 1'b0;
    logic        ch0_req = 1'b0, ch1_req = 1'b0;
    logic [15:0] ch0_data = '0, ch1_data = '0;
    logic        ch0_ack, ch1_ack, tx_err, tRequest, err_sticky, active_ch, busy;
    logic [15:0] tData;
    logic        busIdle = 1'b1, send_done = 1'b0;
`ifdef UL_ARB_STATS_EN
    logic [15:0] stat_ch0_cnt, stat_ch1_cnt;
    logic [7:0]  stat_err_cnt;
    int          m0, m1, me;
`endif

    int cmp = 0, fail = 0;
    int consec = 0;
    bit sticky = 0;

    ul_mcbsp_tx_arbiter #(.DATA_W(16), .MAX_CONSEC(MC), .TIMEOUT_CYC(TO)) dut (
        .McBSPClk(McBSPClk), .nRst(nRst),
        .ch0_req(ch0_req), .ch0_data(ch0_data), .ch0_ack(ch0_ack),
        .ch1_req(ch1_req), .ch1_data(ch1_data), .ch1_ack(ch1_ack),
        .tx_err(tx_err), .tRequest(tRequest), .tData(tData),
        .busIdle(busIdle), .send_done(send_done),
        .err_sticky(err_sticky), .active_ch(active_ch), .busy(busy)
`ifdef UL_ARB_STATS_EN
        , .stat_ch0_cnt(stat_ch0_cnt), .stat_ch1_cnt(stat_ch1_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    always #5 McBSPClk = ~McBSPClk;

    task automatic model_reset();
        consec = 0;
        sticky = 0;
`ifdef UL_ARB_STATS_EN
        m0 = 0; m1 = 0; me = 0;
`endif
    endtask

    // Drives the McBSP side for one word: send_done dly cycles after tRequest
    // (dly outside 1..TO-1 means the driver never answers).
    task automatic serve(input int dly, input bit drop, input bit ech, input logic [15:0] edata);
        int  ack_at;
        bit  eerr, got;
        eerr   = !(dly >= 1 && dly <= TO - 1);
        ack_at = eerr ? TO : dly + 1;
        got    = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge McBSPClk);
            got = tRequest;
        end
        cmp++;
        if (!got) begin
            fail++;
            $display("FAIL treq_wait: tRequest=0 after 10 cycles, required 1");
            return;
        end
        cmp++;
        if ({active_ch, busy, tData} !== {ech, 1'b1, edata}) begin
            fail++;
            $display("FAIL issue: ch/busy/data=%0d/%0d/%h required %0d/1/%h", active_ch, busy, tData, ech, edata);
        end
        sticky = sticky | eerr;
`ifdef UL_ARB_STATS_EN
        if (eerr) me++;
        else if (ech) m1++;
        else m0++;
`endif
        for (int k = 1; k <= ack_at; k++) begin
            @(negedge McBSPClk);
            cmp++;
            if (k < ack_at) begin
                if ({ch0_ack, ch1_ack, tx_err, tRequest, busy} !== 5'b00001) begin
                    fail++;
                    $display("FAIL inflight k=%0d: ack0/ack1/err/treq/busy=%b required 00001", k,
                             {ch0_ack, ch1_ack, tx_err, tRequest, busy});
                end
            end else if ({ch0_ack, ch1_ack, tx_err, tRequest, busy, err_sticky, tData} !==
                         {!ech, ech, eerr, 1'b0, 1'b0, sticky, edata}) begin
                fail++;
                $display("FAIL ack k=%0d: ack0/ack1/err/treq/busy/sticky=%b data=%h required %b data=%h", k,
                         {ch0_ack, ch1_ack, tx_err, tRequest, busy, err_sticky}, tData,
                         {!ech, ech, eerr, 1'b0, 1'b0, sticky}, edata);
            end
            send_done = (k == dly);
            busIdle   = !drop || (dly >= 1 && k >= dly) || k == ack_at;
        end
        send_done = 1'b0;
        busIdle   = 1'b1;
    endtask

    task automatic run_word(input int dly, input bit drop);
        bit e1;
        e1 = ch1_req && (!ch0_req || consec < MC);
        consec = (e1 && ch0_req) ? ((consec < MC) ? consec + 1 : consec) : 0;
        serve(dly, drop, e1, e1 ? ch1_data : ch0_data);
        if (e1) ch1_req = 1'b0;
        else ch0_req = 1'b0;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        repeat (3) @(negedge McBSPClk);
        cmp++;
        if ({ch0_ack, ch1_ack, tx_err, tRequest, err_sticky, active_ch, busy, tData} !== 23'd0) begin
            fail++;
            $display("FAIL reset: outputs=%h required 0",
                     {ch0_ack, ch1_ack, tx_err, tRequest, err_sticky, active_ch, busy, tData});
        end
        nRst = 1'b1;
        model_reset();
    endtask

    task automatic test_ch0_single();
        ch0_req = 1'b1; ch0_data = 16'hA55A;
        run_word(20, 1);
    endtask

    task automatic test_priority();
        for (int i = 0; i < 10; i++) begin
            ch0_req = 1'b1; ch0_data = 16'h0C00 | 16'(i);
            ch1_req = 1'b1; ch1_data = 16'h1C00 | 16'(i);
            run_word(3 + i, 1);
        end
        ch0_req = 1'b0; ch1_req = 1'b0;
    endtask

    task automatic test_timeout();
        ch0_req = 1'b1; ch0_data = 16'hDEAD;
        run_word(0, 1);
        ch1_req = 1'b1; ch1_data = 16'hBEEF;
        run_word(5, 1);
    endtask

    task automatic test_coincident();
        ch1_req = 1'b1; ch1_data = 16'h5AA5;
        run_word(TO - 1, 1);
    endtask

    task automatic test_send_done_in_wait_start();
        ch0_req = 1'b1; ch0_data = 16'h1357;
        run_word(3, 0);
    endtask

    task automatic test_reset_midflight();
        bit got = 0;
        ch0_req = 1'b1; ch0_data = 16'h1234;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge McBSPClk);
            got = tRequest;
        end
        cmp++;
        if (!got) begin
            fail++;
            $display("FAIL rst_treq: tRequest=0 required 1");
        end
        busIdle = 1'b0;
        repeat (3) @(negedge McBSPClk);
        nRst = 1'b0;
        @(negedge McBSPClk);
        cmp++;
        if ({ch0_ack, ch1_ack, tx_err, tRequest, err_sticky, active_ch, busy, tData} !== 23'd0) begin
            fail++;
            $display("FAIL rst_mid: outputs=%h required 0",
                     {ch0_ack, ch1_ack, tx_err, tRequest, err_sticky, active_ch, busy, tData});
        end
        nRst = 1'b1; ch0_req = 1'b0; busIdle = 1'b1;
        model_reset();
        ch1_req = 1'b1; ch1_data = 16'h00FF;
        run_word(20, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            if (!ch0_req && $urandom_range(0, 1)) begin ch0_req = 1'b1; ch0_data = 16'($urandom); end
            if (!ch1_req && $urandom_range(0, 1)) begin ch1_req = 1'b1; ch1_data = 16'($urandom); end
            if (!ch0_req && !ch1_req) begin ch0_req = 1'b1; ch0_data = 16'($urandom); end
            run_word($urandom_range(1, 40), 1'($urandom_range(0, 1)));
        end
        ch0_req = 1'b0; ch1_req = 1'b0;
    endtask

`ifdef UL_ARB_STATS_EN
    task automatic test_stats();
        test_reset();
        for (int i = 0; i < 3; i++) begin ch0_req = 1'b1; ch0_data = 16'(i); run_word(4, 1); end
        for (int i = 0; i < 2; i++) begin ch1_req = 1'b1; ch1_data = 16'(i); run_word(6, 1); end
        ch0_req = 1'b1; ch0_data = 16'hFFFF; run_word(0, 1);
        @(negedge McBSPClk);
        cmp++;
        if ({stat_ch0_cnt, stat_ch1_cnt, stat_err_cnt} !== {16'(m0), 16'(m1), 8'(me)} ||
            {m0, m1, me} !== {32'd3, 32'd2, 32'd1}) begin
            fail++;
            $display("FAIL stats: %0d/%0d/%0d required 3/2/1", stat_ch0_cnt, stat_ch1_cnt, stat_err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ch0_single();
        test_priority();
        test_timeout();
        test_coincident();
        test_send_done_in_wait_start();
        test_reset_midflight();
        test_random();
`ifdef UL_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fail);
        $finish;
    end
endmodule
